// File: rtl/fb_line_renderer_if.sv
// Framebuffer FIFO bus for fb_line_renderer.
// The renderer writes word addresses into the address FIFO and pops
// returned words from the data FIFO.
interface fb_line_renderer_if;
   logic        fb_addr_out_wen;
   logic [15:0] fb_addr_out_wd;
   logic        fb_addr_out_full;
   logic        fb_data_in_ren;
   logic [15:0] fb_data_in_rd;
   logic        fb_data_in_empty;

   modport master (
      output fb_addr_out_wen,
      output fb_addr_out_wd,
      input  fb_addr_out_full,
      output fb_data_in_ren,
      input  fb_data_in_rd,
      input  fb_data_in_empty
   );

   modport slave (
      input  fb_addr_out_wen,
      input  fb_addr_out_wd,
      output fb_addr_out_full,
      input  fb_data_in_ren,
      output fb_data_in_rd,
      output fb_data_in_empty
   );
endinterface

// File: rtl/fb_line_renderer.sv
// fb_line_renderer: prefetches packed framebuffer words through the FIFO
// pair, unpacks them at BPP bits per pixel and drives registered 6-bit RGB.
// Optional feature macro: FB_PALETTE_EN (per-index 18-bit colour palette);
// without it the pixel index is bit-replicated into a grayscale value.
module fb_line_renderer #(
   parameter int BPP     = 2,
   parameter int FB_W    = 512,
   parameter int FB_H    = 256,
   parameter int Y_SHIFT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [10:0]  scr_x,
   input  logic signed [10:0]  scr_y,
   output logic [5:0]          out_red,
   output logic [5:0]          out_green,
   output logic [5:0]          out_blue,
   fb_line_renderer_if.master  fb,
   input  logic                pal_wen,
   input  logic [3:0]          pal_addr,
   input  logic [17:0]         pal_wd,
   output logic                underrun,
   input  logic                underrun_clr
);

   localparam int PPW  = 16 / BPP;
   localparam int SH   = $clog2(PPW);
   localparam int WPR  = FB_W / PPW;
   localparam int NPAL = 1 << BPP;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t          state_q, state_d;

   int              sx, col_i, row_i, p_i;
   logic            row_ok, trig;
   logic [15:0]     addr_d;
   logic            buf_sel_d;

   logic            latch, wen_d, cap, ur_set;
   logic            wen_q, ren_q, sel_q;
   logic [15:0]     wd_q;
   logic [15:0]     buf_q [2];
   logic            underrun_q;

   logic            pix_vis;
   logic [15:0]     pix_word;
   logic [SH-1:0]   pix_off;
   logic [BPP-1:0]  pix_idx;
   logic [17:0]     pix_rgb;
   logic [17:0]     rgb_q;

   // Index bits repeated from the MSB down to fill six bits.
   function automatic logic [5:0] gray(input logic [BPP-1:0] idx);
      logic [5:0] g;
      g = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         g[5-i] = idx[BPP-1-(i%BPP)];
      end
      return g;
   endfunction

   // Screen coordinate decode: prefetch column one word ahead, source row, trigger.
   always_comb begin
      sx        = int'(scr_x);
      col_i     = (sx + PPW) >>> SH;
      row_i     = int'(scr_y) >>> Y_SHIFT;
      p_i       = sx + 1;
      row_ok    = (row_i >= 0) && (row_i < FB_H);
      trig      = ((sx & (PPW - 1)) == 0) && (sx >= -PPW) && row_ok && (col_i < WPR);
      addr_d    = 16'(row_i * WPR + col_i);
      buf_sel_d = col_i[0];
   end

   // Fetch FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Fetch FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (trig) state_d = REQ;
         REQ:     if (!fb.fb_addr_out_full) state_d = WAIT;
         WAIT:    if (!fb.fb_data_in_empty) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Fetch FSM outputs; a trigger while busy is dropped and flagged.
   always_comb begin
      latch  = 1'b0;
      wen_d  = 1'b0;
      cap    = 1'b0;
      ur_set = 1'b0;
      case (state_q)
         IDLE: latch = trig;
         REQ: begin
            wen_d  = !fb.fb_addr_out_full;
            ur_set = trig;
         end
         WAIT: begin
            cap    = !fb.fb_data_in_empty;
            ur_set = trig;
         end
         default: ;
      endcase
   end

   // Strobes, latched request and the two word buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q    <= 1'b0;
         ren_q    <= 1'b0;
         wd_q     <= '0;
         sel_q    <= 1'b0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else begin
         wen_q <= wen_d;
         ren_q <= cap;
         if (latch) begin
            wd_q  <= addr_d;
            sel_q <= buf_sel_d;
         end
         if (cap) buf_q[sel_q] <= fb.fb_data_in_rd;
      end
   end

   // Sticky underrun flag; a new set beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)               underrun_q <= 1'b0;
      else if (ur_set)       underrun_q <= 1'b1;
      else if (underrun_clr) underrun_q <= 1'b0;
   end

   assign fb.fb_addr_out_wen = wen_q;
   assign fb.fb_addr_out_wd  = wd_q;
   assign fb.fb_data_in_ren  = ren_q;
   assign underrun           = underrun_q;

`ifdef FB_PALETTE_EN
   logic [17:0]    pal_q [NPAL];
   logic [BPP-1:0] pal_idx;
   logic           pal_unused;

   assign pal_idx    = pal_addr[BPP-1:0];
   assign pal_unused = ^pal_addr;

   // Palette register file, reset to the grayscale ramp.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NPAL; i++) begin
            pal_q[i] <= {3{gray(BPP'(i))}};
         end
      end else if (pal_wen) begin
         pal_q[pal_idx] <= pal_wd;
      end
   end
`else
   logic pal_unused;
   assign pal_unused = ^{pal_wen, pal_addr, pal_wd};
`endif

   // Pixel lookup one position ahead to cover the output register.
   always_comb begin
      pix_vis  = (p_i >= 0) && (p_i < FB_W) && row_ok;
      pix_word = buf_q[p_i[SH]];
      pix_off  = p_i[SH-1:0];
      pix_idx  = BPP'(pix_word >> (pix_off * BPP));
`ifdef FB_PALETTE_EN
      pix_rgb  = pal_q[pix_idx];
`else
      pix_rgb  = {3{gray(pix_idx)}};
`endif
   end

   // Registered colour output, blanked outside the framebuffer.
   always_ff @(posedge clk) begin
      if (rst || !pix_vis) rgb_q <= '0;
      else                 rgb_q <= pix_rgb;
   end

   assign out_red   = rgb_q[17:12];
   assign out_green = rgb_q[11:6];
   assign out_blue  = rgb_q[5:0];

endmodule

// File: tb/tb_fb_line_renderer.sv
// Directed testbench for fb_line_renderer (BPP=2, 512x256, line doubling).
// A small FIFO responder answers each address with a fixed word pattern.
module tb_fb_line_renderer;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [10:0] scr_x = -11'sd100;
   logic signed [10:0] scr_y = '0;
   logic [5:0]         out_red, out_green, out_blue;
   logic               pal_wen = 1'b0;
   logic [3:0]         pal_addr = '0;
   logic [17:0]        pal_wd = '0;
   logic               underrun;
   logic               underrun_clr = 1'b0;

   int                 checks = 0;
   int                 errors = 0;
   logic [15:0]        wen_log [$];
   logic [15:0]        pend [$];
   int                 ren_cnt = 0;
   logic               hold_empty = 1'b0;
   logic [5:0]         g2 [4] = '{6'h00, 6'h15, 6'h2A, 6'h3F};

   fb_line_renderer_if bus();

   fb_line_renderer #(.BPP(2), .FB_W(512), .FB_H(256), .Y_SHIFT(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .scr_x        (scr_x),
      .scr_y        (scr_y),
      .out_red      (out_red),
      .out_green    (out_green),
      .out_blue     (out_blue),
      .fb           (bus.master),
      .pal_wen      (pal_wen),
      .pal_addr     (pal_addr),
      .pal_wd       (pal_wd),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] fb_word(input logic [15:0] a);
      if (a == 16'h0000)      return 16'hE4E4;
      else if (a == 16'h0001) return 16'h1B1B;
      else                    return 16'hFFFF;
   endfunction

   // Strobe monitor
   always @(posedge clk) begin
      if (bus.fb_addr_out_wen) wen_log.push_back(bus.fb_addr_out_wd);
      if (bus.fb_data_in_ren)  ren_cnt++;
   end

   // Data FIFO responder: answers one cycle after the address is written
   initial bus.fb_addr_out_full = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         pend.delete();
         bus.fb_data_in_empty = 1'b1;
         bus.fb_data_in_rd    = '0;
      end else begin
         if (bus.fb_data_in_ren) bus.fb_data_in_empty = 1'b1;
         else if (bus.fb_data_in_empty && !hold_empty && pend.size() > 0) begin
            bus.fb_data_in_rd    = fb_word(pend.pop_front());
            bus.fb_data_in_empty = 1'b0;
         end
         if (bus.fb_addr_out_wen) pend.push_back(bus.fb_addr_out_wd);
      end
   end

   task automatic tick(input int x, input int y);
      @(negedge clk);
      scr_x = 11'(x);
      scr_y = 11'(y);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(-100, 0);
   endtask

   task automatic test_reset();
      repeat (3) tick(-100, 0);
      checks++;
      if ({out_red, out_green, out_blue, bus.fb_addr_out_wen, bus.fb_data_in_ren,
           bus.fb_addr_out_wd, underrun} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs got rgb=%h wen=%b ren=%b wd=%h ur=%b exp all zero",
                  {out_red, out_green, out_blue}, bus.fb_addr_out_wen,
                  bus.fb_data_in_ren, bus.fb_addr_out_wd, underrun);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_sweep();
      int base_ren;
      logic [17:0] exp;
      wen_log.delete();
      base_ren = ren_cnt;
      for (int x = -8; x <= 15; x++) begin
         tick(x, 0);
         if (x < 0)      exp = '0;
         else if (x < 8) exp = {3{g2[x % 4]}};
         else            exp = {3{g2[3 - (x % 4)]}};
         checks++;
         if ({out_red, out_green, out_blue} !== exp) begin
            errors++;
            $display("FAIL sweep_pixel x=%0d got %h exp %h", x, {out_red, out_green, out_blue}, exp);
         end
         if (x == -7) begin
            checks++;
            if (bus.fb_addr_out_wen !== 1'b0) begin
               errors++;
               $display("FAIL wen_early got %b exp 0", bus.fb_addr_out_wen);
            end
         end
         if (x == -6) begin
            checks++;
            if ({bus.fb_addr_out_wen, bus.fb_addr_out_wd} !== {1'b1, 16'h0000}) begin
               errors++;
               $display("FAIL wen_first got wen=%b wd=%h exp wen=1 wd=0000",
                        bus.fb_addr_out_wen, bus.fb_addr_out_wd);
            end
         end
         if (x == -5) begin
            checks++;
            if (bus.fb_addr_out_wen !== 1'b0) begin
               errors++;
               $display("FAIL wen_one_cycle got %b exp 0", bus.fb_addr_out_wen);
            end
         end
         if (x == -4) begin
            checks++;
            if (bus.fb_data_in_ren !== 1'b1) begin
               errors++;
               $display("FAIL ren_first got %b exp 1", bus.fb_data_in_ren);
            end
         end
      end
      idle(6);
      checks++;
      if (wen_log.size() != 3) begin
         errors++;
         $display("FAIL sweep_wen_count got %0d exp 3", wen_log.size());
      end else if (wen_log[0] !== 16'h0000 || wen_log[1] !== 16'h0001 || wen_log[2] !== 16'h0002) begin
         errors++;
         $display("FAIL sweep_addrs got %h %h %h exp 0000 0001 0002", wen_log[0], wen_log[1], wen_log[2]);
      end
      checks++;
      if (ren_cnt - base_ren != 3) begin
         errors++;
         $display("FAIL sweep_ren_count got %0d exp 3", ren_cnt - base_ren);
      end
   endtask

   task automatic test_underrun();
      int base_ren;
      wen_log.delete();
      base_ren = ren_cnt;
      for (int x = -8; x <= 7; x++) begin
         tick(x, 0);
         if (x == -8) bus.fb_addr_out_full = 1'b1;
         if (x == 4)  bus.fb_addr_out_full = 1'b0;
         if (x == -1) begin
            checks++;
            if (underrun !== 1'b0) begin
               errors++;
               $display("FAIL underrun_before got %b exp 0", underrun);
            end
         end
         if (x == 1) begin
            checks++;
            if (underrun !== 1'b1) begin
               errors++;
               $display("FAIL underrun_set got %b exp 1", underrun);
            end
         end
      end
      idle(8);
      checks++;
      if (wen_log.size() != 1 || ren_cnt - base_ren != 1 || underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun_txn got wen=%0d ren=%0d ur=%b exp wen=1 ren=1 ur=1",
                  wen_log.size(), ren_cnt - base_ren, underrun);
      end
      tick(-100, 0);
      underrun_clr = 1'b1;
      tick(-100, 0);
      underrun_clr = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL underrun_clear got %b exp 0", underrun);
      end
   endtask

   task automatic test_set_wins();
      wen_log.delete();
      tick(-8, 0);
      bus.fb_addr_out_full = 1'b1;
      underrun_clr = 1'b1;
      tick(0, 0);
      tick(-100, 0);
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL set_beats_clear got %b exp 1", underrun);
      end
      tick(-100, 0);
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL clear_held got %b exp 0", underrun);
      end
      underrun_clr = 1'b0;
      bus.fb_addr_out_full = 1'b0;
      idle(8);
      checks++;
      if (wen_log.size() != 1) begin
         errors++;
         $display("FAIL set_wins_wen_count got %0d exp 1", wen_log.size());
      end
   endtask

   task automatic test_row_addr();
      bit seen;
      seen = 1'b0;
      wen_log.delete();
      tick(-8, 5);
      for (int i = 0; i < 10 && !seen; i++) begin
         tick(-100, 0);
         if (wen_log.size() > 0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL row_addr_timeout got no wen exp wd 0080");
      end else if (wen_log[0] !== 16'h0080) begin
         errors++;
         $display("FAIL row_addr got %h exp 0080", wen_log[0]);
      end
      idle(6);
   endtask

   task automatic test_boundary();
      wen_log.delete();
      tick(503, 0);
      tick(504, 0);
      checks++;
      if ({out_red, out_green, out_blue} !== 18'h3FFFF) begin
         errors++;
         $display("FAIL edge_pixel504 got %h exp 3ffff", {out_red, out_green, out_blue});
      end
      tick(505, 0);
      tick(511, 0);
      tick(512, 0);
      checks++;
      if ({out_red, out_green, out_blue} !== 18'h0) begin
         errors++;
         $display("FAIL blank_x512 got %h exp 00000", {out_red, out_green, out_blue});
      end
      idle(4);
      checks++;
      if (wen_log.size() != 0) begin
         errors++;
         $display("FAIL col_wpr_request got %0d wen exp 0", wen_log.size());
      end
      for (int x = -8; x <= 3; x++) begin
         tick(x, 512);
         if (x == 1) begin
            checks++;
            if ({out_red, out_green, out_blue} !== 18'h0) begin
               errors++;
               $display("FAIL blank_row got %h exp 00000", {out_red, out_green, out_blue});
            end
         end
      end
      idle(4);
      checks++;
      if (wen_log.size() != 0) begin
         errors++;
         $display("FAIL row_out_request got %0d wen exp 0", wen_log.size());
      end
   endtask

   task automatic test_palette();
      tick(-100, 0);
      pal_wen  = 1'b1;
      pal_addr = 4'h3;
      pal_wd   = 18'h3F000;
      tick(-100, 0);
      pal_wen  = 1'b0;
      tick(1, 0);
      tick(2, 0);
`ifdef FB_PALETTE_EN
      checks++;
      if ({out_red, out_green, out_blue} !== 18'h3F000) begin
         errors++;
         $display("FAIL pal_red got %h exp 3f000", {out_red, out_green, out_blue});
      end
      pal_wen = 1'b1;
      pal_wd  = 18'h00FC0;
      tick(3, 0);
      pal_wen = 1'b0;
      checks++;
      if ({out_red, out_green, out_blue} !== 18'h3F000) begin
         errors++;
         $display("FAIL pal_same_cycle got %h exp 3f000", {out_red, out_green, out_blue});
      end
      tick(4, 0);
      checks++;
      if ({out_red, out_green, out_blue} !== 18'h00FC0) begin
         errors++;
         $display("FAIL pal_green got %h exp 00fc0", {out_red, out_green, out_blue});
      end
`else
      checks++;
      if ({out_red, out_green, out_blue} !== 18'h3FFFF) begin
         errors++;
         $display("FAIL pal_ignored got %h exp 3ffff", {out_red, out_green, out_blue});
      end
`endif
      idle(2);
   endtask

   task automatic test_reset_mid();
      int base_ren;
      bit seen;
      seen = 1'b0;
      tick(-100, 0);
      hold_empty = 1'b1;
      wen_log.delete();
      tick(-8, 0);
      for (int i = 0; i < 6 && !seen; i++) begin
         tick(-100, 0);
         if (bus.fb_addr_out_wen) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL reset_mid_timeout got no wen exp wen");
      end
      base_ren = ren_cnt;
      rst = 1'b1;
      tick(-100, 0);
      checks++;
      if ({out_red, out_green, out_blue, bus.fb_addr_out_wen, bus.fb_data_in_ren,
           bus.fb_addr_out_wd, underrun} !== 37'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got rgb=%h wen=%b ren=%b wd=%h ur=%b exp all zero",
                  {out_red, out_green, out_blue}, bus.fb_addr_out_wen,
                  bus.fb_data_in_ren, bus.fb_addr_out_wd, underrun);
      end
      idle(2);
      rst = 1'b0;
      hold_empty = 1'b0;
      idle(5);
      checks++;
      if (ren_cnt != base_ren) begin
         errors++;
         $display("FAIL reset_mid_ren got %0d ren exp 0", ren_cnt - base_ren);
      end
      tick(-8, 0);
      tick(-100, 0);
      tick(-100, 0);
      checks++;
      if ({bus.fb_addr_out_wen, bus.fb_addr_out_wd} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL reset_mid_restart got wen=%b wd=%h exp wen=1 wd=0000",
                  bus.fb_addr_out_wen, bus.fb_addr_out_wd);
      end
      idle(6);
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_underrun();
      test_set_wins();
      test_row_addr();
      test_boundary();
      test_palette();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
